mega_mux_of_destiny: RTL and testbench
======================================

// Module: mega_mux_of_destiny
// PURPOSE
// - Registered 5:1 word multiplexer. Selects one of five WIDTH-bit operands (I0..I4) by a 3-bit code S.
// - Presents the selected operand on O one clock later.
// - Used as the ALU result selector: each arithmetic/logic unit (e.g. the XOR_32 slice) drives one input.
// PARAMETERS
// - WIDTH  32  data width of I0..I4 and O
// PORTS
// - clk    input   1      system clock, rising-edge active
// - rst_n  input   1      asynchronous reset, active-low
// - S      input   3      select code; 0..4 select I0..I4, 5..7 are out of range
// - I0     input   WIDTH  operand 0 (S=0)
// - I1     input   WIDTH  operand 1 (S=1)
// - I2     input   WIDTH  operand 2 (S=2)
// - I3     input   WIDTH  operand 3 (S=3)
// - I4     input   WIDTH  operand 4 (S=4)
// - O      output  WIDTH  registered selected operand
// - sel_err output 1      registered out-of-range flag (present only with MEGA_MUX_SELERR_EN)
// - Interface rule: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
// - Reset:
//   - rst_n low forces O=0 immediately, independent of clk; sel_err=0.
//   - Outputs hold 0 while rst_n is low.
//   - First capture happens on the first rising clk after rst_n rises.
// - Each rising clk with rst_n high:
//   - S=0..4: O <= I[S].
//   - S=5,6,7: O <= 0.
// - Latency: exactly 1 cycle from S/I sampled at edge N to O valid after edge N.
//   - No combinational path from S or I to O.
// - S or I changing mid-cycle has no effect until the next rising edge.
// - No enable: O reloads every cycle, so a constant S with changing I tracks I with 1-cycle delay.
// - S containing X/Z is treated as out of range: O <= 0.
// - Pure selection: no arithmetic, no width change, bits routed unmodified.
// - Reset asserted mid-operation: O clears at once.
//   - Operation resumes normally from the next edge after release.
// CONFIGURATION
// - Macro MEGA_MUX_SELERR_EN defined:
//   - Adds output sel_err, registered alongside O.
//   - sel_err <= 1 when sampled S is 5..7 (or X/Z), else 0.
//   - sel_err reset value 0.
// - Macro not defined:
//   - No sel_err port.
//   - Out-of-range S still yields O=0.
// TESTING
// - Reset: rst_n=0 with I0..I4 nonzero, S=0 -> O=0 before any clk edge; O stays 0 until release.
// - Sweep: I0=1, I1=2, I2=4, I3=8, I4=16; S=0..4 one per cycle -> O = 1,2,4,8,16, each 1 cycle after S.
// - Out of range: same inputs, S=5,6,7 -> O=0 each cycle.
//   - With MEGA_MUX_SELERR_EN: sel_err=1 for these codes and 0 for S=0..4.
// - Tracking: S=3 held, I3 = 32'hAAAA_AAAA then 32'h5555_5555 on consecutive cycles -> O follows with 1-cycle lag.
// - Full-width: I4=32'hFFFF_FFFF, I0=0; S alternates 4,0 -> O alternates FFFF_FFFF, 0000_0000.
// - Mid-run reset: S=2, I2=4, O=4; pulse rst_n low between edges -> O=0 asynchronously; returns to 4 one edge after release.

Source files
------------

// File: rtl/mega_mux_of_destiny.sv
// Registered 5:1 word multiplexer used as the ALU result selector.
// Optional out-of-range flag output sel_err is enabled by defining MEGA_MUX_SELERR_EN.
module mega_mux_of_destiny #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
`ifdef MEGA_MUX_SELERR_EN
    output logic             sel_err,
`endif
    output logic [WIDTH-1:0] O
);

    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;
    logic             sel_err_d;
    logic             sel_err_q;

    // Next-value selection; codes 5..7 and any unknown code fall to the default (zero, flagged).
    always_comb begin
        o_d       = {WIDTH{1'b0}};
        sel_err_d = 1'b0;
        case (S)
            3'd0:    o_d = I0;
            3'd1:    o_d = I1;
            3'd2:    o_d = I2;
            3'd3:    o_d = I3;
            3'd4:    o_d = I4;
            default: begin
                o_d       = {WIDTH{1'b0}};
                sel_err_d = 1'b1;
            end
        endcase
    end

    // Output registers, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= {WIDTH{1'b0}};
            sel_err_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign O = o_q;

`ifdef MEGA_MUX_SELERR_EN
    assign sel_err = sel_err_q;
`else
    logic unused_sel_err_s;
    assign unused_sel_err_s = sel_err_q;
`endif

endmodule

// File: tb/tb_mega_mux_of_destiny.sv
// Self-checking bench for mega_mux_of_destiny: vector table plus scoreboard queue,
// with hand-written reset sequences. sel_err is checked when MEGA_MUX_SELERR_EN is defined.
module tb_mega_mux_of_destiny;

    typedef struct {
        string       name;
        logic [2:0]  s;
        logic [31:0] i0, i1, i2, i3, i4;
        logic [31:0] exp_o;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  S;
    logic [31:0] I0, I1, I2, I3, I4;
    logic [31:0] O;
`ifdef MEGA_MUX_SELERR_EN
    logic        sel_err;
`endif

    int          n_checks;
    int          n_fail;
    logic [31:0] last_o;
    exp_t        sb[$];
    vec_t        vecs[$];

    mega_mux_of_destiny #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .S       (S),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .I4      (I4),
`ifdef MEGA_MUX_SELERR_EN
        .sel_err (sel_err),
`endif
        .O       (O)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic [2:0] s,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] i3, input logic [31:0] i4,
                       input logic [31:0] exp_o, input logic exp_err);
        vec_t v;
        v.name = name; v.s = s;
        v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3; v.i4 = i4;
        v.exp_o = exp_o; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Drive at negedge, confirm O holds (no combinational path), then compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        S = v.s; I0 = v.i0; I1 = v.i1; I2 = v.i2; I3 = v.i3; I4 = v.i4;
        e.o = v.exp_o; e.err = v.exp_err;
        sb.push_back(e);
        #1;
        chk({v.name, "_hold"}, O, last_o);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            chk(v.name, O, e.o);
`ifdef MEGA_MUX_SELERR_EN
            chk({v.name, "_err"}, {31'd0, sel_err}, {31'd0, e.err});
`endif
            last_o = e.o;
        end
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_fail   = 0;

        add("sweep0", 3'd0, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd1,  1'b0);
        add("sweep1", 3'd1, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd2,  1'b0);
        add("sweep2", 3'd2, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd4,  1'b0);
        add("sweep3", 3'd3, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd8,  1'b0);
        add("sweep4", 3'd4, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd16, 1'b0);
        add("oor5",   3'd5, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd0,  1'b1);
        add("oor6",   3'd6, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd0,  1'b1);
        add("oor7",   3'd7, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd0,  1'b1);
        add("back0",  3'd0, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd1,  1'b0);
        add("trackA", 3'd3, 32'd1, 32'd2, 32'd4, 32'hAAAA_AAAA, 32'd16, 32'hAAAA_AAAA, 1'b0);
        add("track5", 3'd3, 32'd1, 32'd2, 32'd4, 32'h5555_5555, 32'd16, 32'h5555_5555, 1'b0);
        add("full4a", 3'd4, 32'd0, 32'd2, 32'd4, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add("full0a", 3'd0, 32'd0, 32'd2, 32'd4, 32'd8, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        add("full4b", 3'd4, 32'd0, 32'd2, 32'd4, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add("full0b", 3'd0, 32'd0, 32'd2, 32'd4, 32'd8, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        add("mid2",   3'd2, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd4,  1'b0);

        // Reset asserted before any clock edge with nonzero operands.
        rst_n = 1'b1;
        S  = 3'd0;
        I0 = 32'h1234_5678; I1 = 32'h1111_1111; I2 = 32'h2222_2222;
        I3 = 32'h3333_3333; I4 = 32'h4444_4444;
        #1 rst_n = 1'b0;
        #1 chk("reset_async", O, 32'd0);
`ifdef MEGA_MUX_SELERR_EN
        chk("reset_err", {31'd0, sel_err}, 32'd0);
`endif
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 chk("reset_hold", O, 32'd0);
        end

        // First capture on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        e.o = 32'h1234_5678; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("first_capture", O, e.o);
        last_o = e.o;

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k]);
        end

        // Mid-run reset: last vector left S=2, I2=4 and O=4.
        #2 rst_n = 1'b0;
        #1 chk("mid_async_clear", O, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 chk("mid_held", O, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_release", O, 32'd0);
        @(posedge clk);
        #1 chk("mid_resume", O, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
